// File: rtl/i2c_wb_cmd_seq.sv
// i2c_wb_cmd_seq: Wishbone-master command sequencer for the I2C master core.
// Turns single-byte register write/read commands into the core's register
// accesses (prescale/enable init, TXR/CR writes, SR polling, RXR read).
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_rw/dev/reg/wdata fields
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion with read data / status
//   busy                      init or command in progress
//   wb_*                      8-bit Wishbone master to the core's slave port
module i2c_wb_cmd_seq #(
    parameter logic [15:0] PRESCALE    = 16'd99,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned POLL_LIMIT  = 4096
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       busy,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);

    localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);
    localparam int unsigned STEP_W = 3;

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_AL   = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ACCESS,
        S_POLL,
        S_CHECK,
        S_STOP,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                rw_q, rw_d;
    logic [6:0]          dev_q, dev_d;
    logic [7:0]          reg_q, reg_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                sr_rxack_q, sr_rxack_d;
    logic                sr_al_q, sr_al_d;
    logic [1:0]          err_q, err_d;
    logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
    logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;

    logic                cmd_ready_d, busy_d, rsp_valid_d;
    logic [7:0]          rsp_rdata_d;
    logic [1:0]          rsp_err_d;
    logic [2:0]          wb_adr_d;
    logic [7:0]          wb_dat_d;
    logic                wb_we_d, wb_cyc_d;

    logic                op_en, op_we;
    logic [2:0]          op_adr;
    logic [7:0]          op_dat;
    logic                acc_done, acc_to, poll_last, rd_phase, last_wr;

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_INIT;
            step_q     <= '0;
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            sr_rxack_q <= 1'b0;
            sr_al_q    <= 1'b0;
            err_q      <= '0;
            ack_cnt_q  <= '0;
            poll_cnt_q <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            sr_rxack_q <= sr_rxack_d;
            sr_al_q    <= sr_al_d;
            err_q      <= err_d;
            ack_cnt_q  <= ack_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            cmd_ready  <= cmd_ready_d;
            busy       <= busy_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_err    <= rsp_err_d;
            wb_adr_o   <= wb_adr_d;
            wb_dat_o   <= wb_dat_d;
            wb_we_o    <= wb_we_d;
            wb_stb_o   <= wb_cyc_d;
            wb_cyc_o   <= wb_cyc_d;
        end
    end

    // Next-state, micro-sequence and Wishbone access engine
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        sr_rxack_d  = sr_rxack_q;
        sr_al_d     = sr_al_q;
        err_d       = err_q;
        ack_cnt_d   = ack_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        wb_adr_d    = wb_adr_o;
        wb_dat_d    = wb_dat_o;
        wb_we_d     = wb_we_o;
        wb_cyc_d    = wb_cyc_o;
        op_en       = 1'b0;
        op_we       = 1'b0;
        op_adr      = '0;
        op_dat      = '0;

        // An ack seen while no cycle is open is ignored
        acc_done  = wb_cyc_o && wb_ack_i;
        acc_to    = wb_cyc_o && !wb_ack_i && (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));
        poll_last = (poll_cnt_q == POLL_W'(POLL_LIMIT - 1));
        rd_phase  = rw_q && (step_q == 3'd6);
        last_wr   = !rw_q && (step_q == 3'd5);

        unique case (state_q)
            S_INIT: begin
                op_en = 1'b1;
                op_we = 1'b1;
                case (step_q)
                    3'd0:    begin op_adr = ADR_PRERLO; op_dat = PRESCALE[7:0];  end
                    3'd1:    begin op_adr = ADR_PRERHI; op_dat = PRESCALE[15:8]; end
                    default: begin op_adr = ADR_CTR;    op_dat = 8'h80;          end
                endcase
                // A dead core restarts the init sequence
                if (acc_to) begin
                    step_d = '0;
                end else if (acc_done) begin
                    if (step_q == 3'd2) begin
                        step_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rw_d    = cmd_rw;
                    dev_d   = cmd_dev;
                    reg_d   = cmd_reg;
                    wdata_d = cmd_wdata;
                    step_d  = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                op_en = 1'b1;
                op_we = (step_q != 3'd7);
                case (step_q)
                    3'd0: begin op_adr = ADR_TXR; op_dat = {dev_q, 1'b0}; end
                    3'd1: begin op_adr = ADR_CR;  op_dat = 8'h90; end
                    3'd2: begin op_adr = ADR_TXR; op_dat = reg_q; end
                    3'd3: begin op_adr = ADR_CR;  op_dat = 8'h10; end
                    3'd4: begin op_adr = ADR_TXR; op_dat = rw_q ? {dev_q, 1'b1} : wdata_q; end
                    3'd5: begin op_adr = ADR_CR;  op_dat = rw_q ? 8'h90 : 8'h50; end
                    3'd6: begin op_adr = ADR_CR;  op_dat = 8'h68; end
                    default: begin op_adr = ADR_TXR; op_dat = 8'h00; end
                endcase
                if (acc_to) begin
                    rsp_err_d   = ERR_TO;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else if (acc_done) begin
                    if (step_q == 3'd7) begin
                        rsp_err_d   = ERR_OK;
                        rsp_rdata_d = wb_dat_i;
                        state_d     = S_RESP;
                    end else if (step_q[0] || (step_q == 3'd6)) begin
                        // CR write launched a byte transfer
                        poll_cnt_d = '0;
                        state_d    = S_POLL;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            S_POLL: begin
                op_en  = 1'b1;
                op_adr = ADR_CR;
                if (acc_to) begin
                    rsp_err_d   = ERR_TO;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else if (acc_done) begin
                    if (!wb_dat_i[1]) begin
                        sr_rxack_d = wb_dat_i[7];
                        sr_al_d    = wb_dat_i[5];
                        state_d    = S_CHECK;
                    end else if (poll_last) begin
                        rsp_err_d   = ERR_TO;
                        rsp_rdata_d = '0;
                        state_d     = S_RESP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + POLL_W'(1);
                    end
                end
            end
            S_CHECK: begin
                if (sr_al_q) begin
                    rsp_err_d   = ERR_AL;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else if (sr_rxack_q && !rd_phase) begin
                    err_d   = ERR_NACK;
                    step_d  = '0;
                    state_d = S_STOP;
                end else if (last_wr) begin
                    rsp_err_d   = ERR_OK;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_ACCESS;
                end
            end
            S_STOP: begin
                // Step 0 issues STO, step 1 polls SR until the bus is free
                op_en  = 1'b1;
                op_adr = ADR_CR;
                op_we  = (step_q == 3'd0);
                op_dat = (step_q == 3'd0) ? 8'h40 : 8'h00;
                if (acc_to) begin
                    rsp_err_d   = ERR_TO;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else if (acc_done) begin
                    if (step_q == 3'd0) begin
                        step_d     = 3'd1;
                        poll_cnt_d = '0;
                    end else if (!wb_dat_i[6]) begin
                        rsp_err_d   = err_q;
                        rsp_rdata_d = '0;
                        state_d     = S_RESP;
                    end else if (poll_last) begin
                        rsp_err_d   = ERR_TO;
                        rsp_rdata_d = '0;
                        state_d     = S_RESP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + POLL_W'(1);
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Access engine: hold until ack or timeout, then drop everything,
        // which guarantees one idle cycle before the next launch
        if (wb_cyc_o) begin
            if (wb_ack_i || acc_to) begin
                wb_cyc_d = 1'b0;
                wb_we_d  = 1'b0;
                wb_adr_d = '0;
                wb_dat_d = '0;
            end else begin
                ack_cnt_d = ack_cnt_q + ACK_W'(1);
            end
        end else if (op_en) begin
            wb_cyc_d  = 1'b1;
            wb_we_d   = op_we;
            wb_adr_d  = op_adr;
            wb_dat_d  = op_dat;
            ack_cnt_d = '0;
        end

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = !cmd_ready_d;
        rsp_valid_d = (state_d == S_RESP);
    end

endmodule

// File: tb/tb_i2c_wb_cmd_seq.sv
// Bench for i2c_wb_cmd_seq: behavioural core slave with registered ack,
// expected register writes queued at command issue and compared on completion.
module tb_i2c_wb_cmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev = '0;
    logic [7:0] cmd_reg = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       busy;
    logic [2:0] wb_adr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = '0;
    logic       wb_we, wb_stb, wb_cyc;
    logic       wb_ack = 1'b0;

    i2c_wb_cmd_seq dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rw   (cmd_rw),
        .cmd_dev  (cmd_dev),
        .cmd_reg  (cmd_reg),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we),
        .wb_stb_o (wb_stb),
        .wb_cyc_o (wb_cyc),
        .wb_ack_i (wb_ack)
    );

    always #5 clk = ~clk;

    // Slave knobs
    logic       stall = 1'b0;
    logic       nack_mode = 1'b0;
    logic       tip_stuck = 1'b0;
    logic [7:0] rxr_val = 8'h00;

    // Slave state and logs
    int         tip_left = 0;
    int         busy_left = 0;
    logic       rxack = 1'b0;
    logic [10:0] wlog [0:255];
    int         wr_n = 0;
    int         acc_n = 0;
    int         sr_reads = 0;

    always @(posedge clk) begin
        if (rst) begin
            wb_ack    <= 1'b0;
            tip_left  <= 0;
            busy_left <= 0;
            rxack     <= 1'b0;
        end else begin
            wb_ack <= 1'b0;
            if (wb_cyc && wb_stb && wb_ack) begin
                acc_n <= acc_n + 1;
                if (wb_we) begin
                    wlog[wr_n[7:0]] <= {wb_adr, wb_dat_o};
                    wr_n <= wr_n + 1;
                end
            end
            if (wb_cyc && wb_stb && !wb_ack && !stall) begin
                wb_ack <= 1'b1;
                if (wb_we && wb_adr == 3'd4) begin
                    if (wb_dat_o == 8'h40) begin
                        busy_left <= 2;
                    end else if (wb_dat_o[7] || wb_dat_o[5] || wb_dat_o[4]) begin
                        tip_left <= 1;
                        rxack    <= nack_mode && (wb_dat_o == 8'h90);
                    end
                end
                if (!wb_we && wb_adr == 3'd4) begin
                    wb_dat_i <= {rxack, busy_left != 0, 1'b0, 3'b000,
                                 tip_stuck || (tip_left != 0), 1'b0};
                    if (tip_left != 0)  tip_left  <= tip_left - 1;
                    if (busy_left != 0) busy_left <= busy_left - 1;
                    sr_reads <= sr_reads + 1;
                end
                if (!wb_we && wb_adr == 3'd3) wb_dat_i <= rxr_val;
            end
        end
    end

    // Scoreboard and counters
    int          errors = 0;
    int          checks = 0;
    logic [10:0] exp_q [$];
    int          rd_idx = 0;
    logic [1:0]  r_err;
    logic [7:0]  r_rdata;
    int          cyc_cnt;
    int          sr_base;
    int          acc_base;
    int          n;
    logic        got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_writes(input string tag);
        logic [10:0] e;
        chk({tag, "_count"}, 32'(wr_n - rd_idx), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rd_idx < wr_n) begin
            e = exp_q.pop_front();
            chk(tag, 32'(wlog[rd_idx[7:0]]), 32'(e));
            rd_idx++;
        end
        exp_q.delete();
        rd_idx = wr_n;
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Called at a negedge right after reset release
    task automatic wait_init(input string tag);
        logic ready_seen;
        int   edges;
        ready_seen = 1'b0;
        edges = 0;
        push_wr(3'd0, 8'h63);
        push_wr(3'd1, 8'h00);
        push_wr(3'd2, 8'h80);
        acc_base = acc_n;
        for (int i = 1; i <= 60 && !ready_seen; i++) begin
            @(negedge clk);
            if (i == 1) chk({tag, "_busy_first"}, 32'(busy), 32'd1);
            if (cmd_ready) begin
                ready_seen = 1'b1;
                edges = i;
            end
        end
        chk({tag, "_ready"}, 32'(ready_seen), 32'd1);
        chk({tag, "_cycles"}, 32'(edges), 32'd9);
        chk({tag, "_accesses"}, 32'(acc_n - acc_base), 32'd3);
        check_writes({tag, "_wr"});
    endtask

    task automatic issue_cmd(input logic rw, input logic [6:0] dv, input logic [7:0] rg,
                             input logic [7:0] wd);
        logic acc;
        acc = 1'b0;
        cmd_rw = rw; cmd_dev = dv; cmd_reg = rg; cmd_wdata = wd;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (cmd_ready) begin
                acc = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
                chk("ready_drops", 32'(cmd_ready), 32'd0);
                chk("busy_after_accept", 32'(busy), 32'd1);
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        chk("accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        got = 1'b0;
        cyc_cnt = 0;
        for (int i = 0; i < budget && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                r_err = rsp_err;
                r_rdata = rsp_rdata;
            end else begin
                if (wb_cyc) cyc_cnt++;
                @(negedge clk);
            end
        end
        chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        chk({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        rst = 1'b0;
        wait_init("init");

        // Register write
        issue_cmd(1'b0, 7'h50, 8'h12, 8'hA5);
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h12); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'hA5); push_wr(3'd4, 8'h50);
        wait_rsp("wr", 500);
        chk("wr_err", 32'(r_err), 32'd0);
        chk("wr_rdata", 32'(r_rdata), 32'd0);
        check_writes("wr_seq");

        // Register read
        rxr_val = 8'h3C;
        issue_cmd(1'b1, 7'h50, 8'h07, 8'h00);
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h07); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'hA1); push_wr(3'd4, 8'h90);
        push_wr(3'd4, 8'h68);
        wait_rsp("rd", 500);
        chk("rd_err", 32'(r_err), 32'd0);
        chk("rd_rdata", 32'(r_rdata), 32'h3C);
        check_writes("rd_seq");

        // Address NACK on a read: STO then poll Busy, rdata cleared
        nack_mode = 1'b1;
        sr_base = sr_reads;
        issue_cmd(1'b1, 7'h50, 8'h07, 8'h00);
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90); push_wr(3'd4, 8'h40);
        wait_rsp("nack", 500);
        chk("nack_err", 32'(r_err), 32'd1);
        chk("nack_rdata", 32'(r_rdata), 32'd0);
        chk("nack_sr_reads", 32'(sr_reads - sr_base), 32'd5);
        check_writes("nack_seq");
        nack_mode = 1'b0;

        // Missing ack: cycle held exactly ACK_TIMEOUT cycles
        stall = 1'b1;
        issue_cmd(1'b0, 7'h21, 8'h01, 8'h02);
        wait_rsp("ackto", 200);
        chk("ackto_err", 32'(r_err), 32'd3);
        chk("ackto_cyc_cycles", 32'(cyc_cnt), 32'd16);
        chk("ackto_cyc_low", 32'({wb_cyc, wb_stb}), 32'd0);
        check_writes("ackto_seq");
        stall = 1'b0;

        // TIP stuck: poll limit reached, no STO
        tip_stuck = 1'b1;
        sr_base = sr_reads;
        issue_cmd(1'b0, 7'h50, 8'h12, 8'hA5);
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        wait_rsp("pollto", 20000);
        chk("pollto_err", 32'(r_err), 32'd3);
        chk("pollto_sr_reads", 32'(sr_reads - sr_base), 32'd4096);
        check_writes("pollto_seq");
        tip_stuck = 1'b0;

        // Reset mid-read while stb is high
        issue_cmd(1'b1, 7'h50, 8'h07, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (wb_stb && wb_adr == 3'd3 && wb_dat_o == 8'h07) got = 1'b1;
            else @(negedge clk);
        end
        chk("mid_stb_seen", 32'(got), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cyc", 32'({wb_cyc, wb_stb}), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'({busy, cmd_ready}), 32'd0);
        @(negedge clk);
        chk("mid_rst_rsp2", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        rd_idx = wr_n;
        rst = 1'b0;
        wait_init("reinit");
        issue_cmd(1'b0, 7'h50, 8'h12, 8'hA5);
        push_wr(3'd3, 8'hA0); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h12); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'hA5); push_wr(3'd4, 8'h50);
        wait_rsp("post", 500);
        chk("post_err", 32'(r_err), 32'd0);
        check_writes("post_seq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
